// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//
// Per-register pending-write tracker that sits beside the ID stage. Each of
// the NREG architectural registers has a small up/down counter. The counter
// goes up when an instruction that writes the register issues out of ID, and
// goes down when its write-back retires. A source operand whose register
// still has an outstanding writer raises a combinational stall.
//
// Handshake: this block has no valid/ready pair. An instruction in ID
// "issues" in a cycle when id_valid & wb_en_id & ~flush & ~hazard. A
// write-back "retires" in any cycle where writeBackEn is high. Both are
// accounted for on the rising clock edge of that cycle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   src1/use_src1     ID first source index / source is read
//   src2/use_src2     ID second source index / source is read
//   dest_id/wb_en_id  ID destination index / instruction writes dest_id
//   id_valid          ID holds a real instruction
//   flush             kill of the ID instruction this cycle
//   Dest_wb           write-back destination index
//   writeBackEn       write-back valid this cycle
//   hazard            combinational stall request
//   pending_mask      registered, bit r set when count[r] != 0
//   in_flight         registered sum of all counters, saturating at 31
//   err_underflow     sticky flag: a retire hit a register with count 0
module reg_scoreboard #(
  parameter int CNT_W = 2,
  parameter int NREG  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic        use_src1,
  input  logic        use_src2,
  input  logic [3:0]  dest_id,
  input  logic        wb_en_id,
  input  logic        id_valid,
  input  logic        flush,
  input  logic [3:0]  Dest_wb,
  input  logic        writeBackEn,
  output logic        hazard,
  output logic [15:0] pending_mask,
  output logic [4:0]  in_flight,
  output logic        err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [15:0]      pending_mask_q, pending_mask_d;
  logic [4:0]       in_flight_q, in_flight_d;
  logic             err_q, err_d;

  logic [NREG-1:0]  eff_pending;
  logic [NREG-1:0]  full;
  logic             retire;
  logic             issue;
  logic [5:0]       sum;

  assign retire = writeBackEn;

  // A register retiring this cycle is written by the register file on the
  // negedge, so ID already sees the new value: subtract the retire before
  // deciding whether the register is still pending or full.
  always_comb begin
    eff_pending = '0;
    full        = '0;
    for (int r = 0; r < NREG; r++) begin
      logic ret_hit;
      ret_hit        = retire && (Dest_wb == r[3:0]);
      eff_pending[r] = (cnt_q[r] != '0) && !(ret_hit && (cnt_q[r] == CNT_ONE));
      full[r]        = (cnt_q[r] == CNT_MAX) && !ret_hit;
    end
  end

  always_comb begin
    hazard = id_valid && !flush &&
             ((use_src1 && eff_pending[src1]) ||
              (use_src2 && eff_pending[src2]) ||
              (wb_en_id && full[dest_id]));
    issue  = id_valid && wb_en_id && !flush && !hazard;
  end

  // Issue and retire on the same register cancel. A retire to a zero count
  // is dropped (count stays 0) and flagged. Increment cannot overflow: a
  // full counter blocks issue unless the same register retires, in which
  // case the two cancel.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      logic inc, dec;
      inc = issue  && (dest_id == r[3:0]);
      dec = retire && (Dest_wb == r[3:0]) && (cnt_q[r] != '0);
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) cnt_d[r] = cnt_q[r] + CNT_ONE;
      if (dec && !inc) cnt_d[r] = cnt_q[r] - CNT_ONE;
    end
    err_d = err_q || (retire && (cnt_q[Dest_wb] == '0));
  end

  // Derived outputs are registered from the post-update counters.
  always_comb begin
    sum            = '0;
    pending_mask_d = '0;
    for (int r = 0; r < NREG; r++) begin
      sum               = sum + 6'(cnt_d[r]);
      pending_mask_d[r] = (cnt_d[r] != '0);
    end
    in_flight_d = (sum > 6'd31) ? 5'd31 : sum[4:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      pending_mask_q <= '0;
      in_flight_q    <= '0;
      err_q          <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      pending_mask_q <= pending_mask_d;
      in_flight_q    <= in_flight_d;
      err_q          <= err_d;
    end
  end

  assign pending_mask  = pending_mask_q;
  assign in_flight     = in_flight_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard
//
// Directed vectors for reg_scoreboard. Each vector holds the inputs for one
// clock cycle. The driver pushes the expected response (hazard during the
// cycle, registered outputs after the edge) into exp_q. A separate monitor
// samples hazard at the negedge of every active cycle and the registered
// outputs just after the following posedge, then pops and compares.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic [3:0]  src1, src2, dest_id, Dest_wb;
  logic        use_src1, use_src2, wb_en_id, id_valid, flush, writeBackEn;
  logic        hazard;
  logic [15:0] pending_mask;
  logic [4:0]  in_flight;
  logic        err_underflow;

  reg_scoreboard #(.CNT_W(2), .NREG(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .src1         (src1),
    .src2         (src2),
    .use_src1     (use_src1),
    .use_src2     (use_src2),
    .dest_id      (dest_id),
    .wb_en_id     (wb_en_id),
    .id_valid     (id_valid),
    .flush        (flush),
    .Dest_wb      (Dest_wb),
    .writeBackEn  (writeBackEn),
    .hazard       (hazard),
    .pending_mask (pending_mask),
    .in_flight    (in_flight),
    .err_underflow(err_underflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Packed expectation: {hazard, pending_mask, in_flight, err_underflow}
  logic [22:0] exp_q[$];
  string       tag_q[$];
  logic        chk_vld;
  int          n_vec;
  int          n_miss;

  // ---------------- driver ----------------
  task automatic vec(input string tag, input logic r,
                     input logic [3:0] s1, input logic u1,
                     input logic [3:0] s2, input logic u2,
                     input logic [3:0] d, input logic wb,
                     input logic v, input logic fl,
                     input logic [3:0] dwb, input logic wbe,
                     input logic e_hz, input logic [15:0] e_m,
                     input logic [4:0] e_if, input logic e_err);
    @(posedge clk);
    #2;
    rst = r; src1 = s1; use_src1 = u1; src2 = s2; use_src2 = u2;
    dest_id = d; wb_en_id = wb; id_valid = v; flush = fl;
    Dest_wb = dwb; writeBackEn = wbe;
    chk_vld = 1'b1;
    exp_q.push_back({e_hz, e_m, e_if, e_err});
    tag_q.push_back(tag);
  endtask

  task automatic go_idle();
    @(posedge clk);
    #2;
    rst = 1'b0; src1 = '0; use_src1 = 1'b0; src2 = '0; use_src2 = 1'b0;
    dest_id = '0; wb_en_id = 1'b0; id_valid = 1'b0; flush = 1'b0;
    Dest_wb = '0; writeBackEn = 1'b0;
    chk_vld = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic        hz_s;
  logic [22:0] exp_v, act_v;
  string       tag_v;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_vld) begin
        hz_s = hazard;
        @(posedge clk);
        #1;
        act_v = {hz_s, pending_mask, in_flight, err_underflow};
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL no_expect: output seen with empty expected queue, got %h", act_v);
        end else begin
          exp_v = exp_q.pop_front();
          tag_v = tag_q.pop_front();
          n_vec++;
          if (act_v !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got hz=%0b mask=%h if=%0d err=%0b, want hz=%0b mask=%h if=%0d err=%0b",
                     tag_v, act_v[22], act_v[21:6], act_v[5:1], act_v[0],
                     exp_v[22], exp_v[21:6], exp_v[5:1], exp_v[0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0; n_miss = 0; chk_vld = 1'b0;
    rst = 1'b1; src1 = '0; use_src1 = 1'b0; src2 = '0; use_src2 = 1'b0;
    dest_id = '0; wb_en_id = 1'b0; id_valid = 1'b0; flush = 1'b0;
    Dest_wb = '0; writeBackEn = 1'b0;

    //   tag            rst s1 u1 s2 u2 d  wb v  fl dwb wbe  hz mask      if err
    vec("reset",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 16'h0000, 0, 0);
    vec("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 16'h0000, 0, 0);
    // RAW on R3, released by the write-back bypass
    vec("iss_r3",       0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0,   0, 16'h0008, 1, 0);
    vec("raw_r3_a",     0, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0,   1, 16'h0008, 1, 0);
    vec("raw_r3_b",     0, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0,   1, 16'h0008, 1, 0);
    vec("byp_r3",       0, 3, 1, 0, 0, 0, 0, 1, 0, 3, 1,   0, 16'h0000, 0, 0);
    vec("idle_r3",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 16'h0000, 0, 0);
    // Saturate R5 at 3 writers
    vec("iss_r5_1",     0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0,   0, 16'h0020, 1, 0);
    vec("iss_r5_2",     0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0,   0, 16'h0020, 2, 0);
    vec("iss_r5_3",     0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0,   0, 16'h0020, 3, 0);
    vec("full_r5",      0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0,   1, 16'h0020, 3, 0);
    vec("full_ret_r5",  0, 0, 0, 0, 0, 5, 1, 1, 0, 5, 1,   0, 16'h0020, 3, 0);
    vec("ret_r5_1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1,   0, 16'h0020, 2, 0);
    vec("ret_r5_2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1,   0, 16'h0020, 1, 0);
    vec("ret_r5_3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1,   0, 16'h0000, 0, 0);
    // Simultaneous issue and retire on R7
    vec("iss_r7",       0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0,   0, 16'h0080, 1, 0);
    vec("iss_ret_r7",   0, 0, 0, 0, 0, 7, 1, 1, 0, 7, 1,   0, 16'h0080, 1, 0);
    vec("ret_r7",       0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1,   0, 16'h0000, 0, 0);
    // Flush masks a src2 hazard and blocks the issue
    vec("iss_r2",       0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0,   0, 16'h0004, 1, 0);
    vec("flush_src2",   0, 0, 0, 2, 1, 4, 1, 1, 1, 0, 0,   0, 16'h0004, 1, 0);
    vec("raw_src2",     0, 0, 0, 2, 1, 4, 1, 1, 0, 0, 0,   1, 16'h0004, 1, 0);
    vec("ret_r2",       0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1,   0, 16'h0000, 0, 0);
    // Edge indices R15 and R0
    vec("iss_r15",      0, 0, 0, 0, 0, 15, 1, 1, 0, 0, 0,  0, 16'h8000, 1, 0);
    vec("iss_r0",       0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 16'h8001, 2, 0);
    vec("src_unused",   0, 15, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 16'h8001, 2, 0);
    vec("raw_r0_src2",  0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0,   1, 16'h8001, 2, 0);
    vec("ret_r15",      0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 1,  0, 16'h0001, 1, 0);
    vec("ret_r0",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 16'h0000, 0, 0);
    // Underflow is sticky until reset
    vec("under_r9",     0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 1,   0, 16'h0000, 0, 1);
    vec("err_hold",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 16'h0000, 0, 1);
    vec("bubble_wb",    0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0,   0, 16'h0000, 0, 1);
    vec("rst_clr",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 16'h0000, 0, 0);
    // Reset mid-operation drops tracking; stale write-back underflows
    vec("iss_r1",       0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0,   0, 16'h0002, 1, 0);
    vec("rst_mid",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 16'h0000, 0, 0);
    vec("stale_wb_r1",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 16'h0000, 0, 1);
    go_idle();

    repeat (5) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected responses never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
